// File: rtl/pc_unit_if.sv
// Fetch request channel between the PC unit (master) and instruction memory (slave).
interface pc_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            fetch_valid;
  logic            fetch_ready;
  logic [XLEN-1:0] fetch_pc;
  logic            fetch_ilen;

  modport master (
    output fetch_valid,
    output fetch_pc,
    input  fetch_ready,
    input  fetch_ilen
  );

  modport slave (
    input  fetch_valid,
    input  fetch_pc,
    output fetch_ready,
    output fetch_ilen
  );
endinterface

// File: rtl/pc_unit.sv
// Program counter and control-transfer unit for the frisc core: owns the fetch
// PC, computes link/target for JAL/JALR/branch/AUIPC, applies traps/redirects.
module pc_unit #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int unsigned     C_EXT        = 0
) (
  input  logic            clk,
  input  logic            reset,
  pc_unit_if.master       fetch,
  input  logic            stall,
  input  logic            ex_valid,
  input  logic [1:0]      ex_kind,
  input  logic            ex_taken,
  input  logic            ex_ilen,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_rs1,
  input  logic [XLEN-1:0] ex_imm,
  input  logic            trap_req,
  output logic [XLEN-1:0] link,
  output logic [XLEN-1:0] target,
  output logic            res_valid,
  output logic            misaligned,
  output logic            redirect
);

  localparam logic [1:0] BOOT   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] BUBBLE = 2'd2;

  localparam logic [1:0] K_BRANCH = 2'b00;
  localparam logic [1:0] K_JAL    = 2'b01;
  localparam logic [1:0] K_JALR   = 2'b11;

  logic [1:0]      state;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] fetch_step;
  logic [XLEN-1:0] ex_step;
  logic [XLEN-1:0] pc_rel;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] tgt;
  logic            transfer;
  logic            misal;
  logic            accept;

  assign fetch.fetch_pc    = pc_q;
  assign fetch.fetch_valid = (state == RUN) && !stall;
  assign accept            = fetch.fetch_valid && fetch.fetch_ready;

  // Instruction lengths and control-transfer target for the execute stage
  always_comb begin
    fetch_step = ((C_EXT != 0) && fetch.fetch_ilen) ? XLEN'(2) : XLEN'(4);
    ex_step    = ((C_EXT != 0) && ex_ilen) ? XLEN'(2) : XLEN'(4);
    pc_rel     = ex_pc + ex_imm;
    jalr_sum   = ex_rs1 + ex_imm;
    tgt        = (ex_kind == K_JALR) ? {jalr_sum[XLEN-1:1], 1'b0} : pc_rel;
    transfer   = ex_valid && ((ex_kind == K_JAL) || (ex_kind == K_JALR) ||
                              ((ex_kind == K_BRANCH) && ex_taken));
    misal      = transfer && (C_EXT == 0) && tgt[1];
  end

  // Execute results, fetch PC and fetch state; trap beats transfer beats sequential fetch
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_VECTOR;
      link       <= '0;
      target     <= '0;
      res_valid  <= 1'b0;
      misaligned <= 1'b0;
      redirect   <= 1'b0;
      state      <= BOOT;
    end else begin
      if (ex_valid) begin
        link   <= ex_pc + ex_step;
        target <= tgt;
      end
      res_valid  <= ex_valid;
      misaligned <= misal;
      redirect   <= 1'b0;
      if (trap_req) begin
        pc_q     <= TRAP_VECTOR;
        redirect <= 1'b1;
        state    <= BUBBLE;
      end else if (transfer && !misal) begin
        pc_q     <= tgt;
        redirect <= 1'b1;
        state    <= BUBBLE;
      end else begin
        if (accept) pc_q <= pc_q + fetch_step;
        state <= RUN;
      end
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: one instance with C_EXT=0 and one with C_EXT=1,
// both driven by the same stimulus.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_ready;
  logic        fetch_ilen;
  logic        stall;
  logic        ex_valid;
  logic [1:0]  ex_kind;
  logic        ex_taken;
  logic        ex_ilen;
  logic [31:0] ex_pc;
  logic [31:0] ex_rs1;
  logic [31:0] ex_imm;
  logic        trap_req;

  logic [31:0] link0, target0, link1, target1;
  logic        rv0, mis0, rd0, rv1, mis1, rd1;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  pc_unit_if #(.XLEN(32)) fif0 ();
  pc_unit_if #(.XLEN(32)) fif1 ();

  assign fif0.fetch_ready = fetch_ready;
  assign fif0.fetch_ilen  = fetch_ilen;
  assign fif1.fetch_ready = fetch_ready;
  assign fif1.fetch_ilen  = fetch_ilen;

  pc_unit #(.XLEN(32), .RESET_VECTOR(32'h0), .TRAP_VECTOR(32'h100), .C_EXT(0)) dut0 (
    .clk(clk), .reset(reset), .fetch(fif0), .stall(stall),
    .ex_valid(ex_valid), .ex_kind(ex_kind), .ex_taken(ex_taken), .ex_ilen(ex_ilen),
    .ex_pc(ex_pc), .ex_rs1(ex_rs1), .ex_imm(ex_imm), .trap_req(trap_req),
    .link(link0), .target(target0), .res_valid(rv0), .misaligned(mis0), .redirect(rd0)
  );

  pc_unit #(.XLEN(32), .RESET_VECTOR(32'h0), .TRAP_VECTOR(32'h100), .C_EXT(1)) dut1 (
    .clk(clk), .reset(reset), .fetch(fif1), .stall(stall),
    .ex_valid(ex_valid), .ex_kind(ex_kind), .ex_taken(ex_taken), .ex_ilen(ex_ilen),
    .ex_pc(ex_pc), .ex_rs1(ex_rs1), .ex_imm(ex_imm), .trap_req(trap_req),
    .link(link1), .target(target1), .res_valid(rv1), .misaligned(mis1), .redirect(rd1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Fetch PC and valid of both instances when they are expected to agree
  task automatic fetch_both(input string tag, input logic [31:0] pc, input logic fv);
    check({tag, " pc0"}, fif0.fetch_pc, pc);
    check({tag, " fv0"}, 32'(fif0.fetch_valid), 32'(fv));
    check({tag, " pc1"}, fif1.fetch_pc, pc);
    check({tag, " fv1"}, 32'(fif1.fetch_valid), 32'(fv));
  endtask

  task automatic ex_drive(input logic [1:0] kind, input logic taken,
                          input logic [31:0] pc, input logic [31:0] rs1,
                          input logic [31:0] imm);
    ex_valid = 1'b1;
    ex_kind  = kind;
    ex_taken = taken;
    ex_pc    = pc;
    ex_rs1   = rs1;
    ex_imm   = imm;
  endtask

  initial begin
    reset = 1'b1; fetch_ready = 1'b1; fetch_ilen = 1'b0; stall = 1'b0;
    ex_valid = 1'b0; ex_kind = 2'b00; ex_taken = 1'b0; ex_ilen = 1'b0;
    ex_pc = '0; ex_rs1 = '0; ex_imm = '0; trap_req = 1'b0;
    tick();
    tick();
    fetch_both("reset", 32'h0, 1'b0);
    check("reset link", link0, 32'h0);
    check("reset target", target0, 32'h0);
    check("reset res_valid", 32'(rv0), 32'h0);
    check("reset redirect", 32'(rd0), 32'h0);
    check("reset misaligned", 32'(mis0), 32'h0);

    // Boot cycle, then sequential fetch 0,4,8
    reset = 1'b0;
    #1;
    check("boot fv", 32'(fif0.fetch_valid), 32'h0);
    tick(); fetch_both("run0", 32'h0, 1'b1);
    tick(); fetch_both("run4", 32'h4, 1'b1);
    tick(); fetch_both("run8", 32'h8, 1'b1);

    // Memory not ready: PC holds with valid asserted
    fetch_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); fetch_both("hold8", 32'h8, 1'b1);
    end
    fetch_ready = 1'b1;
    tick(); fetch_both("runC", 32'hC, 1'b1);

    // JAL 0x40 + 0x20
    ex_drive(2'b01, 1'b0, 32'h40, 32'h0, 32'h20);
    tick();
    ex_valid = 1'b0;
    fetch_both("jal", 32'h60, 1'b0);
    check("jal target", target0, 32'h60);
    check("jal link", link0, 32'h44);
    check("jal redirect", 32'(rd0), 32'h1);
    check("jal res_valid", 32'(rv0), 32'h1);
    tick();
    fetch_both("jal after bubble", 32'h60, 1'b1);
    check("jal redirect pulse", 32'(rd0), 32'h0);
    check("idle res_valid", 32'(rv0), 32'h0);
    check("idle target hold", target0, 32'h60);
    tick(); fetch_both("run64", 32'h64, 1'b1);

    // JALR clears bit 0
    ex_drive(2'b11, 1'b0, 32'h80, 32'h101, 32'h4);
    tick();
    ex_valid = 1'b0;
    fetch_both("jalr", 32'h104, 1'b0);
    check("jalr target", target1, 32'h104);
    check("jalr link", link1, 32'h84);
    check("jalr redirect", 32'(rd1), 32'h1);
    tick(); fetch_both("jalr after bubble", 32'h104, 1'b1);

    // Not-taken branch: no redirect, fetch keeps going
    ex_drive(2'b00, 1'b0, 32'h200, 32'h0, 32'h10);
    tick();
    ex_valid = 1'b0;
    fetch_both("br nt", 32'h108, 1'b1);
    check("br nt target", target0, 32'h210);
    check("br nt redirect", 32'(rd0), 32'h0);

    // JAL to 0x42, 2-byte instruction: misaligned without C, redirect with C
    ex_drive(2'b01, 1'b0, 32'h40, 32'h0, 32'h2);
    ex_ilen = 1'b1;
    tick();
    ex_valid = 1'b0; ex_ilen = 1'b0;
    check("mis d0", 32'(mis0), 32'h1);
    check("mis d0 redirect", 32'(rd0), 32'h0);
    check("mis d0 pc", fif0.fetch_pc, 32'h10C);
    check("mis d0 link", link0, 32'h44);
    check("mis d1", 32'(mis1), 32'h0);
    check("mis d1 redirect", 32'(rd1), 32'h1);
    check("mis d1 pc", fif1.fetch_pc, 32'h42);
    check("mis d1 link", link1, 32'h42);
    tick();
    check("mis d0 clear", 32'(mis0), 32'h0);
    check("mis d0 pc next", fif0.fetch_pc, 32'h110);
    check("mis d1 bubble pc", fif1.fetch_pc, 32'h42);
    fetch_ilen = 1'b1;
    tick();
    fetch_ilen = 1'b0;
    check("cext ilen2 pc", fif1.fetch_pc, 32'h44);
    check("noc ilen ignored pc", fif0.fetch_pc, 32'h114);

    // Trap together with a taken branch: trap wins, target still updates
    ex_drive(2'b00, 1'b1, 32'h300, 32'h0, 32'h40);
    trap_req = 1'b1;
    tick();
    ex_valid = 1'b0; trap_req = 1'b0;
    fetch_both("trap", 32'h100, 1'b0);
    check("trap redirect", 32'(rd0), 32'h1);
    check("trap target", target0, 32'h340);
    tick(); fetch_both("trap after bubble", 32'h100, 1'b1);

    // Stall, then a redirect during stall
    stall = 1'b1;
    #1;
    check("stall fv", 32'(fif0.fetch_valid), 32'h0);
    tick(); fetch_both("stall hold", 32'h100, 1'b0);
    ex_drive(2'b01, 1'b0, 32'h500, 32'h0, 32'h100);
    tick();
    ex_valid = 1'b0;
    fetch_both("stall jal", 32'h600, 1'b0);
    check("stall jal redirect", 32'(rd0), 32'h1);
    tick(); fetch_both("stall run", 32'h600, 1'b0);
    tick(); fetch_both("stall run2", 32'h600, 1'b0);

    // Reset mid-stall overrides a simultaneous trap and transfer
    reset = 1'b1; trap_req = 1'b1;
    ex_drive(2'b01, 1'b0, 32'h700, 32'h0, 32'h8);
    tick();
    fetch_both("midreset", 32'h0, 1'b0);
    check("midreset link", link0, 32'h0);
    check("midreset target", target0, 32'h0);
    check("midreset res_valid", 32'(rv0), 32'h0);
    check("midreset redirect", 32'(rd0), 32'h0);
    check("midreset misaligned", 32'(mis0), 32'h0);
    reset = 1'b0; trap_req = 1'b0; ex_valid = 1'b0; stall = 1'b0;
    tick(); fetch_both("post reset run", 32'h0, 1'b1);

    // Wrap at the top of the address space
    ex_drive(2'b01, 1'b0, 32'hFFFF_FF00, 32'h0, 32'hFC);
    tick();
    ex_valid = 1'b0;
    fetch_both("wrap jal", 32'hFFFF_FFFC, 1'b0);
    check("wrap link", link0, 32'hFFFF_FF04);
    tick(); fetch_both("wrap run", 32'hFFFF_FFFC, 1'b1);
    tick(); fetch_both("wrap", 32'h0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter and control-transfer unit for the frisc core.
- Owns the architectural fetch PC and drives a valid/ready fetch request.
- Registers the execute-stage link value (pc+ILEN) and control-transfer target for JAL, JALR, branch and AUIPC.
- Applies redirects, traps and stalls, and flags misaligned targets.

Parameters:
- XLEN, 32: datapath and address width.
- RESET_VECTOR, 0: fetch PC value after reset.
- TRAP_VECTOR, 32'h0000_0100: fetch PC value on trap entry.
- C_EXT, 0: when 1, 2-byte alignment is legal and ex_ilen is honoured; when 0, every instruction is 4 bytes.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- fetch_valid  out  1  fetch request valid
- fetch_ready  in  1  instruction memory accepts request
- fetch_pc  out  XLEN  address of current fetch request
- fetch_ilen  in  1  length of fetched instruction, sampled on accept (1 = 2 bytes; ignored if C_EXT=0)
- stall  in  1  hold fetch PC and suppress fetch_valid
- ex_valid  in  1  execute-stage instruction present
- ex_kind  in  2  00 branch, 01 JAL, 10 AUIPC, 11 JALR
- ex_taken  in  1  branch condition outcome (used only for kind 00)
- ex_ilen  in  1  1 = 2-byte instruction (C_EXT=1 only)
- ex_pc  in  XLEN  PC of the execute-stage instruction
- ex_rs1  in  XLEN  rs1 value (JALR)
- ex_imm  in  XLEN  sign-extended immediate, already selected by the decoder
- trap_req  in  1  take trap this cycle
- link  out  XLEN  registered ex_pc + 4, or + 2 when C_EXT=1 and ex_ilen=1
- target  out  XLEN  registered control-transfer or AUIPC result
- res_valid  out  1  link/target valid, one cycle after ex_valid
- misaligned  out  1  registered; target alignment violation
- redirect  out  1  registered; a redirect was applied to fetch_pc this cycle (used to flush the pipeline)

Behaviour:
- Reset (sync, high):
  - fetch_pc=RESET_VECTOR; link=0; target=0.
  - res_valid=0; misaligned=0; redirect=0; fetch_valid=0.
  - State goes to BOOT.
  - Reset asserted mid-operation overrides every other input in that cycle.
- States:
  - BOOT: fetch_valid=0 for exactly one cycle, then RUN.
  - RUN: fetch_valid = !stall.
  - BUBBLE: entered for one cycle after any redirect; fetch_valid=0; then RUN.
- Sequential fetch:
  - An accept is the cycle where fetch_valid && fetch_ready.
  - On accept, fetch_pc advances by 4, or by 2 when C_EXT=1 and fetch_ilen=1.
  - Otherwise fetch_pc holds.
  - Addition wraps modulo 2^XLEN (0xFFFFFFFC+4 = 0).
- Execute datapath (registered, latency 1), when ex_valid:
  - target by ex_kind:
    - JAL, branch, AUIPC: ex_pc+ex_imm.
    - JALR: (ex_rs1+ex_imm) & ~1.
  - link = ex_pc + ilen.
  - res_valid = ex_valid.
  - When ex_valid=0, link and target hold and res_valid=0.
- Redirect conditions:
  - Transfer: ex_valid && (kind==JAL || kind==JALR || (kind==branch && ex_taken)). AUIPC never redirects.
  - Misaligned: a transfer whose computed target has bit1=1 while C_EXT=0.
    - misaligned=1 next cycle.
    - No redirect; fetch continues.
    - Trap logic is expected to respond via trap_req.
- Priority, highest first: reset > trap_req > aligned transfer > stall > sequential advance.
  - trap_req: fetch_pc <= TRAP_VECTOR; redirect=1; state BUBBLE. Any simultaneous transfer is discarded; res_valid/link/target still update.
  - Aligned transfer: fetch_pc <= computed target; redirect=1; state BUBBLE.
  - Stall: fetch_pc holds; an outstanding accept cannot occur because fetch_valid=0.
- Redirect is registered: fetch_pc shows the new value the cycle after the trigger.
  - redirect pulses for one cycle, aligned with the new fetch_pc.
- A redirect during stall still updates fetch_pc; after BUBBLE the unit waits in RUN with fetch_valid=0 until stall drops.
- fetch_pc must stay stable while fetch_valid=1 and fetch_ready=0, unless a redirect or trap occurs.

Test Plan:
- Reset then run, fetch_ready=1, C_EXT=0 -> fetch_valid=0 for one cycle, then fetch_pc sequence 0,4,8,0xC.
- fetch_ready=0 for 3 cycles at fetch_pc=8 -> fetch_pc holds 8 and fetch_valid stays 1; resumes to 0xC after ready.
- ex_valid, JAL, ex_pc=0x40, ex_imm=0x20 -> next cycle target=0x60, link=0x44, redirect=1, fetch_pc=0x60; fetch_valid=0 for one bubble cycle.
- JALR, rs1=0x101, imm=0x4 -> target=0x104; branch with ex_taken=0 -> no redirect, sequential fetch continues.
- C_EXT=0, JAL to 0x42 -> misaligned=1, redirect=0; C_EXT=1 with the same stimulus -> redirect to 0x42; fetch_ilen=1 at 0x42 -> next fetch_pc 0x44.
- trap_req together with taken branch -> fetch_pc=TRAP_VECTOR (0x100); reset asserted mid-stall -> fetch_pc=RESET_VECTOR, all outputs 0; fetch_pc=0xFFFFFFFC accepted -> wraps to 0.
